// File: rtl/hazard_controller_pkg.sv
// Shared encodings and control-bundle types for the pipeline hazard controller.
package hazard_controller_pkg;

  localparam int HC_STATE_WIDTH = 3;

  typedef enum logic [HC_STATE_WIDTH-1:0] {
    HC_RUN      = 3'd0,
    HC_MEM_WAIT = 3'd1,
    HC_EX_BUSY  = 3'd2,
    HC_SQUASH   = 3'd3
  } hc_state_e;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic ex_mem_flush;
    logic mem_wb_flush;
  } hc_ctrl_t;

  localparam hc_ctrl_t HC_CTRL_NONE = 8'b0000_0000;
  // Whole front of the pipe frozen, MEM/WB gets a bubble while dmem is busy.
  localparam hc_ctrl_t HC_CTRL_FREEZE = 8'b1101_0101;
  // Front held, EX/MEM bubbled while the multi-cycle unit works.
  localparam hc_ctrl_t HC_CTRL_MC = 8'b1101_0010;
  localparam hc_ctrl_t HC_CTRL_LOAD_USE = 8'b1100_1000;
  localparam hc_ctrl_t HC_CTRL_REDIRECT = 8'b0010_1000;

endpackage

// File: rtl/hazard_controller_load_use_detect.sv
// Load-use hazard compare between the ID-stage operands and the EX-stage load destination.
module load_use_detect (
  input  logic       id_valid,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       ex_valid,
  input  logic [4:0] ex_rd_addr,
  input  logic       ex_mem_read,
  output logic       load_use
);

  logic rs1_hit_s;
  logic rs2_hit_s;

  assign rs1_hit_s = id_uses_rs1 & (id_rs1_addr == ex_rd_addr);
  assign rs2_hit_s = id_uses_rs2 & (id_rs2_addr == ex_rd_addr);
  // x0 never carries a dependency.
  assign load_use  = ex_valid & ex_mem_read & (ex_rd_addr != 5'd0) & id_valid & (rs1_hit_s | rs2_hit_s);

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencer: per-stage stall/flush for the 5-stage core, episode FSM and perf counters.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int CNT_W          = 32,
  parameter int REDIRECT_EXTRA = 0,
  parameter int MC_TIMEOUT     = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_mem_read,
  input  logic             ex_mc_start,
  input  logic             ex_mc_done,
  input  logic             ex_redirect,
  input  logic             dmem_stall,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic [2:0]       state,
  output logic             mc_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int TO_W = $clog2(MC_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(MC_TIMEOUT);

  hc_state_e        state_r, state_nxt_s;
  logic [1:0]       squash_r, squash_nxt_s;
  logic [TO_W-1:0]  to_cnt_r, to_nxt_s;
  logic             done_r, done_nxt_s;
  logic             mc_timeout_r, timeout_hit_s;
  logic             redirect_taken_s;
  logic             load_use_s;
  hc_ctrl_t         ctrl_s;
  logic [CNT_W-1:0] stall_cycles_r, flush_count_r;

  load_use_detect u_load_use_detect (
    .id_valid    (id_valid),
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_valid    (ex_valid),
    .ex_rd_addr  (ex_rd_addr),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use_s)
  );

  // Next-state and per-stage control decode; unknown encodings fall into the RUN branch.
  always_comb begin
    ctrl_s           = HC_CTRL_NONE;
    state_nxt_s      = state_r;
    squash_nxt_s     = squash_r;
    to_nxt_s         = to_cnt_r;
    done_nxt_s       = done_r;
    timeout_hit_s    = 1'b0;
    redirect_taken_s = 1'b0;
    case (state_r)
      HC_MEM_WAIT: begin
        if (dmem_stall) begin
          ctrl_s = HC_CTRL_FREEZE;
        end else begin
          state_nxt_s = HC_RUN;
        end
      end
      HC_EX_BUSY: begin
        to_nxt_s      = (to_cnt_r == TO_MAX) ? to_cnt_r : to_cnt_r + TO_W'(1);
        timeout_hit_s = (to_nxt_s == TO_MAX);
        if (ex_mc_done) begin
          done_nxt_s = 1'b1;
        end else begin
          done_nxt_s = done_r;
        end
        if (dmem_stall) begin
          ctrl_s = HC_CTRL_FREEZE;
        end else if (done_r) begin
          // Exit cycle: nothing held, the multi-cycle result drops into EX/MEM.
          state_nxt_s = HC_RUN;
          done_nxt_s  = 1'b0;
        end else begin
          ctrl_s = HC_CTRL_MC;
        end
      end
      HC_SQUASH: begin
        if (dmem_stall) begin
          ctrl_s = HC_CTRL_FREEZE;
        end else begin
          squash_nxt_s = squash_r - 2'd1;
          if (squash_r <= 2'd1) begin
            state_nxt_s = HC_RUN;
          end else begin
            state_nxt_s = HC_SQUASH;
          end
        end
        ctrl_s.if_id_flush = 1'b1;
      end
      default: begin
        if (dmem_stall) begin
          ctrl_s      = HC_CTRL_FREEZE;
          state_nxt_s = HC_MEM_WAIT;
        end else if (ex_redirect & ex_valid) begin
          ctrl_s           = HC_CTRL_REDIRECT;
          redirect_taken_s = 1'b1;
          if (REDIRECT_EXTRA > 0) begin
            state_nxt_s  = HC_SQUASH;
            squash_nxt_s = 2'(REDIRECT_EXTRA);
          end else begin
            state_nxt_s = HC_RUN;
          end
        end else if (ex_mc_start & ex_valid & ~ex_mc_done) begin
          ctrl_s      = HC_CTRL_MC;
          state_nxt_s = HC_EX_BUSY;
          to_nxt_s    = '0;
          done_nxt_s  = 1'b0;
        end else if (load_use_s) begin
          ctrl_s      = HC_CTRL_LOAD_USE;
          state_nxt_s = HC_RUN;
        end else begin
          state_nxt_s = HC_RUN;
        end
      end
    endcase
    // Outputs are quiet for as long as reset is held, whatever the inputs say.
    if (reset) begin
      ctrl_s = HC_CTRL_NONE;
    end else begin
      ctrl_s = ctrl_s;
    end
  end

  // FSM, episode counters, sticky watchdog and saturating perf counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= HC_RUN;
      squash_r       <= 2'd0;
      to_cnt_r       <= '0;
      done_r         <= 1'b0;
      mc_timeout_r   <= 1'b0;
      stall_cycles_r <= '0;
      flush_count_r  <= '0;
    end else begin
      state_r      <= state_nxt_s;
      squash_r     <= squash_nxt_s;
      to_cnt_r     <= to_nxt_s;
      done_r       <= done_nxt_s;
      mc_timeout_r <= mc_timeout_r | timeout_hit_s;
      if (ctrl_s.pc_stall && (stall_cycles_r != {CNT_W{1'b1}})) begin
        stall_cycles_r <= stall_cycles_r + CNT_W'(1);
      end
      if (redirect_taken_s && (flush_count_r != {CNT_W{1'b1}})) begin
        flush_count_r <= flush_count_r + CNT_W'(1);
      end
    end
  end

  assign pc_stall     = ctrl_s.pc_stall;
  assign if_id_stall  = ctrl_s.if_id_stall;
  assign if_id_flush  = ctrl_s.if_id_flush;
  assign id_ex_stall  = ctrl_s.id_ex_stall;
  assign id_ex_flush  = ctrl_s.id_ex_flush;
  assign ex_mem_stall = ctrl_s.ex_mem_stall;
  assign ex_mem_flush = ctrl_s.ex_mem_flush;
  assign mem_wb_flush = ctrl_s.mem_wb_flush;
  assign state        = state_r;
  assign mc_timeout   = mc_timeout_r;
  assign stall_cycles = stall_cycles_r;
  assign flush_count  = flush_count_r;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed checks of hazard_controller: load-use, multi-cycle, redirect squash, dmem freeze, watchdog, reset.
module tb_hazard_controller;

  // Control vector bit order: pc_stall if_id_stall if_id_flush id_ex_stall id_ex_flush ex_mem_stall ex_mem_flush mem_wb_flush
  localparam logic [7:0] C_NONE   = 8'h00;
  localparam logic [7:0] C_FREEZE = 8'hD5;
  localparam logic [7:0] C_MC     = 8'hD2;
  localparam logic [7:0] C_LU     = 8'hC8;
  localparam logic [7:0] C_REDIR  = 8'h28;
  localparam logic [7:0] C_SQ     = 8'h20;
  localparam logic [7:0] C_SQ_FRZ = 8'hF5;

  logic        clk;
  logic        reset;
  logic        id_valid, id_uses_rs1, id_uses_rs2;
  logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic        ex_valid, ex_mem_read, ex_mc_start, ex_mc_done, ex_redirect, dmem_stall;
  logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic        ex_mem_stall, ex_mem_flush, mem_wb_flush, mc_timeout;
  logic [2:0]  state;
  logic [31:0] stall_cycles, flush_count;
  logic [7:0]  ctrl;

  int tests_run = 0;
  int tests_failed = 0;

  hazard_controller #(
    .CNT_W          (32),
    .REDIRECT_EXTRA (2),
    .MC_TIMEOUT     (64)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs1_addr  (id_rs1_addr),
    .id_rs2_addr  (id_rs2_addr),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .ex_valid     (ex_valid),
    .ex_rd_addr   (ex_rd_addr),
    .ex_mem_read  (ex_mem_read),
    .ex_mc_start  (ex_mc_start),
    .ex_mc_done   (ex_mc_done),
    .ex_redirect  (ex_redirect),
    .dmem_stall   (dmem_stall),
    .pc_stall     (pc_stall),
    .if_id_stall  (if_id_stall),
    .if_id_flush  (if_id_flush),
    .id_ex_stall  (id_ex_stall),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_stall (ex_mem_stall),
    .ex_mem_flush (ex_mem_flush),
    .mem_wb_flush (mem_wb_flush),
    .state        (state),
    .mc_timeout   (mc_timeout),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  assign ctrl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                 ex_mem_stall, ex_mem_flush, mem_wb_flush};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 1'b0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ex_rd_addr = 5'd0;
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mc_start = 1'b0;
    ex_mc_done = 1'b0; ex_redirect = 1'b0; dmem_stall = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    #2 reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check_eq("reset_ctrl", 32'(ctrl), 32'(C_NONE));
    check_eq("reset_state", 32'(state), 32'd0);
    check_eq("reset_stall_cycles", stall_cycles, 32'd0);
    check_eq("reset_flush_count", flush_count, 32'd0);
    check_eq("reset_timeout", 32'(mc_timeout), 32'd0);

    // lw x5 in EX, add x6,x5,x1 in ID
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd_addr = 5'd5;
    id_valid = 1'b1; id_rs1_addr = 5'd5; id_uses_rs1 = 1'b1; id_rs2_addr = 5'd1; id_uses_rs2 = 1'b1;
    #1 check_eq("lu_stall", 32'(ctrl), 32'(C_LU));
    tick();
    ex_valid = 1'b0; ex_mem_read = 1'b0;
    #1 check_eq("lu_after_bubble", 32'(ctrl), 32'(C_NONE));
    check_eq("lu_state", 32'(state), 32'd0);
    check_eq("lu_stall_cycles", stall_cycles, 32'd1);

    // No hazard for x0 or for an unused operand; rs2 path does hazard
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd_addr = 5'd0; id_rs1_addr = 5'd0;
    #1 check_eq("lu_rd_zero", 32'(ctrl), 32'(C_NONE));
    ex_rd_addr = 5'd5; id_rs1_addr = 5'd5; id_uses_rs1 = 1'b0;
    #1 check_eq("lu_rs1_unused", 32'(ctrl), 32'(C_NONE));
    id_rs1_addr = 5'd3; id_uses_rs1 = 1'b1; id_rs2_addr = 5'd5;
    #1 check_eq("lu_rs2_hit", 32'(ctrl), 32'(C_LU));
    clear_inputs();
    #1 check_eq("idle_ctrl", 32'(ctrl), 32'(C_NONE));

    // Multi-cycle op, done five cycles after start
    ex_valid = 1'b1; ex_mc_start = 1'b1;
    #1 check_eq("mc_start", 32'(ctrl), 32'(C_MC));
    tick();
    for (int i = 1; i <= 5; i++) begin
      ex_mc_done = (i == 5);
      #1 check_eq($sformatf("mc_busy_%0d", i), 32'(ctrl), 32'(C_MC));
      check_eq($sformatf("mc_state_%0d", i), 32'(state), 32'd2);
      tick();
    end
    ex_mc_done = 1'b0;
    #1 check_eq("mc_exit_ctrl", 32'(ctrl), 32'(C_NONE));
    tick();
    clear_inputs();
    #1 check_eq("mc_back_run", 32'(state), 32'd0);
    check_eq("mc_stall_cycles", stall_cycles, 32'd7);

    // Redirect with two extra squash cycles
    ex_valid = 1'b1; ex_redirect = 1'b1;
    #1 check_eq("redir_flush", 32'(ctrl), 32'(C_REDIR));
    tick();
    clear_inputs();
    #1 check_eq("redir_sq1_state", 32'(state), 32'd3);
    check_eq("redir_sq1_ctrl", 32'(ctrl), 32'(C_SQ));
    tick();
    #1 check_eq("redir_sq2_ctrl", 32'(ctrl), 32'(C_SQ));
    tick();
    #1 check_eq("redir_done_state", 32'(state), 32'd0);
    check_eq("redir_done_ctrl", 32'(ctrl), 32'(C_NONE));
    check_eq("redir_flush_count", flush_count, 32'd1);
    check_eq("redir_no_stall", stall_cycles, 32'd7);

    // dmem stall for three cycles in front of a redirect
    ex_valid = 1'b1; ex_redirect = 1'b1; dmem_stall = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      #1 check_eq($sformatf("dmem_frz_%0d", i), 32'(ctrl), 32'(C_FREEZE));
      tick();
    end
    dmem_stall = 1'b0;
    #1 check_eq("dmem_release", 32'(ctrl), 32'(C_NONE));
    check_eq("dmem_release_state", 32'(state), 32'd1);
    tick();
    #1 check_eq("dmem_redirect_5th", 32'(ctrl), 32'(C_REDIR));
    tick();
    clear_inputs();
    // dmem stall inside SQUASH keeps the squash count
    dmem_stall = 1'b1;
    #1 check_eq("sq_dmem_ctrl", 32'(ctrl), 32'(C_SQ_FRZ));
    tick();
    dmem_stall = 1'b0;
    #1 check_eq("sq_dmem_hold_state", 32'(state), 32'd3);
    check_eq("sq_after_dmem_1", 32'(ctrl), 32'(C_SQ));
    tick();
    #1 check_eq("sq_after_dmem_2", 32'(ctrl), 32'(C_SQ));
    tick();
    #1 check_eq("sq_dmem_run", 32'(state), 32'd0);
    check_eq("dmem_flush_count", flush_count, 32'd2);
    check_eq("dmem_stall_cycles", stall_cycles, 32'd11);

    // Multi-cycle op with dmem stall overlapping the done pulse
    ex_valid = 1'b1; ex_mc_start = 1'b1;
    #1 check_eq("mcd_start", 32'(ctrl), 32'(C_MC));
    tick();
    dmem_stall = 1'b1; ex_mc_done = 1'b1;
    #1 check_eq("mcd_frz_1", 32'(ctrl), 32'(C_FREEZE));
    tick();
    ex_mc_done = 1'b0;
    #1 check_eq("mcd_frz_2", 32'(ctrl), 32'(C_FREEZE));
    check_eq("mcd_frz_state", 32'(state), 32'd2);
    tick();
    dmem_stall = 1'b0;
    #1 check_eq("mcd_exit", 32'(ctrl), 32'(C_NONE));
    tick();
    clear_inputs();
    #1 check_eq("mcd_run", 32'(state), 32'd0);
    check_eq("mcd_stall_cycles", stall_cycles, 32'd14);

    // Watchdog: no done for 64 busy cycles
    ex_valid = 1'b1; ex_mc_start = 1'b1;
    tick();
    for (int i = 1; i <= 63; i++) tick();
    check_eq("wd_before", 32'(mc_timeout), 32'd0);
    tick();
    check_eq("wd_set", 32'(mc_timeout), 32'd1);
    check_eq("wd_state", 32'(state), 32'd2);
    tick();
    check_eq("wd_sticky", 32'(mc_timeout), 32'd1);

    // Asynchronous reset mid-episode with inputs still asserted
    #2 reset = 1'b1;
    #1 check_eq("areset_state", 32'(state), 32'd0);
    check_eq("areset_ctrl", 32'(ctrl), 32'(C_NONE));
    check_eq("areset_timeout", 32'(mc_timeout), 32'd0);
    check_eq("areset_stall_cycles", stall_cycles, 32'd0);
    clear_inputs();
    tick();
    reset = 1'b0;
    #1 check_eq("post_reset_ctrl", 32'(ctrl), 32'(C_NONE));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
